// File: rtl/counter_sched_if.sv
// Handshake bundle between the requesting logic, the shared counter and
// the scheduler. The scheduler connects through the slave modport.
interface counter_sched_if #(
  parameter int NBITS_COUNTER = 8,
  parameter int NREQ          = 4
);
  logic [NREQ-1:0]               Req;
  logic [NREQ*NBITS_COUNTER-1:0] Duration;
  logic [NBITS_COUNTER-1:0]      Count;
  logic                          Cnt_Enable;
  logic                          Cnt_Reset;
  logic [NREQ-1:0]               Grant;
  logic [NREQ-1:0]               Done;
  logic                          Busy;

  // Requesters plus counter side: drive requests, durations and count.
  modport master (
    output Req, Duration, Count,
    input  Cnt_Enable, Cnt_Reset, Grant, Done, Busy
  );

  // Scheduler side: sole driver of the counter controls and the grants.
  modport slave (
    input  Req, Duration, Count,
    output Cnt_Enable, Cnt_Reset, Grant, Done, Busy
  );
endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one counter between NREQ requesters.
// A winner's Duration is latched, the counter is cleared for one cycle,
// then enabled until it equals the latched target, and Done pulses once.
module counter_sched #(
  parameter int NBITS_COUNTER = 8,
  parameter int NREQ          = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  counter_sched_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state, next_state;
  logic [IW-1:0]            last;
  logic [IW-1:0]            idx;
  logic [NBITS_COUNTER-1:0] target;
  logic [NREQ-1:0]          grant_q, done_q;
  logic                     busy_q;

  logic [NBITS_COUNTER-1:0] dur_arr [NREQ];
  logic [IW-1:0]            pick;
  logic                     any_req;
  logic                     owner_req;
  logic [NREQ-1:0]          grant_d, done_d;
  logic                     busy_d;
  logic                     cnt_enable, cnt_reset;

  assign any_req   = |bus.Req;
  assign owner_req = bus.Req[idx];

  // Unpack the flat Duration bus into one slice per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      dur_arr[i] = bus.Duration[i*NBITS_COUNTER +: NBITS_COUNTER];
    end
  end

  // Round-robin search: first active request strictly after 'last', wrapping.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    logic          found;
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    pick     = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last) + k) % NREQ;
      cand_idx = IW'(cand);
      if (!found && bus.Req[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  // State register plus registered Grant/Done/Busy and the latched job.
  always_ff @(posedge Clock) begin
    // NOTE: the latched index and target are ordinary flops, so they can be
    // cleared by reset along with the control state.
    if (Reset) begin
      state   <= IDLE;
      last    <= IW'(NREQ - 1);
      idx     <= '0;
      target  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, so the order of these statements does not matter.
      state   <= next_state;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      if (state == IDLE && any_req) begin
        idx    <= pick;
        last   <= pick;
        target <= dur_arr[pick];
      end
    end
  end

  // Next-state logic; an owner dropping its request aborts CLEAR or RUN.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = CLEAR;
      CLEAR:   next_state = owner_req ? RUN : IDLE;
      RUN: begin
        if (!owner_req)                next_state = IDLE;
        else if (bus.Count == target)  next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: counter controls are combinational, the rest are next values
  // for the output flops so Grant/Done/Busy align with the state register.
  always_comb begin
    cnt_reset  = (state == CLEAR);
    cnt_enable = (state == RUN) && (bus.Count != target);
    busy_d     = (next_state != IDLE);
    if (next_state == IDLE)
      grant_d = '0;
    else if (state == IDLE)
      grant_d = NREQ'(1) << pick;
    else
      grant_d = grant_q;
    done_d = (next_state == DONE) ? (NREQ'(1) << idx) : '0;
  end

  assign bus.Cnt_Enable = cnt_enable;
  assign bus.Cnt_Reset  = cnt_reset;
  assign bus.Grant      = grant_q;
  assign bus.Done       = done_q;
  assign bus.Busy       = busy_q;

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler that shares one `counter` instance (Enable/Reset/Clock/Output) between NREQ requesters, each needing a timed interval.
- Arbitrates requests and latches the winner's Duration.
- Clears the counter, enables it until Output equals Duration, then pulses that requester's Done.
- Sits between the requesting logic and the counter, and is the only driver of the counter's Enable and Reset.

Parameters:
- NBITS_COUNTER, 8: width of counter Output and of each Duration slice; matches the counter's parameter.
- NREQ, 4: number of requesters (>= 2).

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  NREQ  level request, one bit per requester.
- Duration  in  NREQ*NBITS_COUNTER  packed target counts; requester i uses bits [i*NBITS_COUNTER +: NBITS_COUNTER].
- Count  in  NBITS_COUNTER  counter Output.
- Cnt_Enable  out  1  to counter Enable.
- Cnt_Reset  out  1  to counter Reset.
- Grant  out  NREQ  one-hot owner of the counter; all-zero when idle.
- Done  out  NREQ  one-cycle completion pulse for requester i.
- Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (sampled high at a rising edge), including mid-operation:
  - State goes to IDLE.
  - Grant=0, Done=0, Busy=0, Cnt_Enable=0, Cnt_Reset=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has highest priority.
  - Latched index and target are cleared.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If any Req bit is high, select the first requester searching from last+1 upward, with wrap-around.
  - Latch its index and Duration slice into target.
  - Set last=index, set Grant one-hot, then go to CLEAR.
  - Otherwise remain in IDLE.
- CLEAR (exactly 1 cycle):
  - Cnt_Reset=1, Cnt_Enable=0, then go to RUN.
- RUN:
  - Cnt_Reset=0.
  - Cnt_Enable=(Count != target), combinational, so the counter stops holding exactly target.
  - When Count==target, go to DONE.
- DONE (exactly 1 cycle):
  - Done[index]=1, Cnt_Enable=0, Grant still asserted, then go to IDLE.
  - In IDLE, Grant clears and Done clears.
- Registered vs combinational outputs:
  - Grant, Done and Busy are registered (decoded from the state register).
  - Cnt_Enable and Cnt_Reset are combinational from state, Count and target.
- Latency:
  - Grant rises 1 cycle after Req is sampled in IDLE.
  - Done pulses D+2 cycles after Grant rises (CLEAR, then D+1 RUN cycles).
  - Minimum one IDLE cycle between consecutive grants.
- Duration=0: CLEAR, then one RUN cycle (Count==0 matches immediately, Cnt_Enable stays 0), then DONE.
- Duration=2^NBITS_COUNTER-1: legal; the counter never wraps because Enable drops at the match.
- Duration changes after the grant are ignored; the latched target is used.
- Abort: if Req[index] drops while in CLEAR or RUN, go to IDLE next cycle.
  - No Done pulse, Cnt_Enable=0.
  - The pointer keeps the aborted index.
- Req dropping during DONE does not suppress the Done pulse.
- Non-granted requesters are not queued separately; their held Req is served in round-robin order.
- Done and Grant are never asserted for more than one requester at a time.

Test Plan (NREQ=4, NBITS_COUNTER=8, with a real `counter` instance attached):
1. Reset held 2 cycles, then Req=0001, Duration[0]=5:
   - All outputs 0 during reset.
   - Grant=0001 next cycle.
   - Cnt_Reset high for 1 cycle.
   - Cnt_Enable high for 5 cycles; Count ends at 5.
   - Done=0001 pulse exactly 7 cycles after Grant rises; Busy falls next cycle.
2. Req=1111 held, all Durations=3: grants issued in order 0001, 0010, 0100, 1000, 0001, with one Done per grant.
3. Req=0101 held, Duration[2]=0: after requester 0 completes, Grant=0100 and Done=0100 is 2 cycles later; Count stays 0.
4. Duration[1]=255, Req=0010: Count reaches 255 and stays there; no wrap to 0; Done after 257 cycles.
5. Abort: Req=1000 with Duration=20, Req[3] dropped when Count=7:
   - No Done pulse; Cnt_Enable=0 and Busy=0 on the next cycle.
   - A following Req=1001 grants requester 0 first.
6. Reset asserted mid-RUN at Count=4: next cycle Grant=0, Cnt_Enable=0, Busy=0; the next request is served from requester 0 priority.
